// File: rtl/fft_mag_capture_pkg.sv
// Shared types and defaults for the FFT magnitude frame capture block.
package fft_cap_pkg;

   localparam int unsigned AW_DEF    = 10;
   localparam int unsigned DW_DEF    = 16;
   localparam int unsigned FRAME_LEN = 1 << AW_DEF;

   // Fixed encodings kept compatible with the legacy state register.
   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_ARMED   = 2'd1;
   localparam logic [1:0] ST_CAPTURE = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   typedef enum logic [1:0] {
      IDLE    = ST_IDLE,
      ARMED   = ST_ARMED,
      CAPTURE = ST_CAPTURE,
      DONE    = ST_DONE
   } cap_state_t;

endpackage

// File: rtl/fft_mag_capture_if.sv
// Control, FFT result stream and host read port of the capture block.
interface fft_cap_if import fft_cap_pkg::*; #(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
);
   logic                 arm;
   logic                 opd;
   logic                 sod;
   logic signed [DW-1:0] xk_re;
   logic signed [DW-1:0] xk_im;
   logic                 busy;
   logic                 done;
   logic                 err;
   logic                 rd_en;
   logic [AW-1:0]        rd_addr;
   logic [DW-1:0]        rd_data;
   logic                 rd_valid;

   modport master (
      output arm, opd, sod, xk_re, xk_im, rd_en, rd_addr,
      input  busy, done, err, rd_data, rd_valid
   );

   modport slave (
      input  arm, opd, sod, xk_re, xk_im, rd_en, rd_addr,
      output busy, done, err, rd_data, rd_valid
   );
endinterface

// File: rtl/fft_mag_capture_mag.sv
// One-stage registered |re|+|im| magnitude with saturation and valid bit.
module fft_cap_mag import fft_cap_pkg::*; #(
   parameter int unsigned DW = DW_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   input  logic signed [DW-1:0] re,
   input  logic signed [DW-1:0] im,
   output logic                 out_valid,
   output logic [DW-1:0]        mag
);
   logic [DW-1:0] abs_re;
   logic [DW-1:0] abs_im;
   logic [DW:0]   sum;

   // Two's-complement negate taken as unsigned, so the most negative input maps to 2^(DW-1).
   always_comb begin
      abs_re = re[DW-1] ? ((~re) + DW'(1)) : re;
      abs_im = im[DW-1] ? ((~im) + DW'(1)) : im;
      sum    = {1'b0, abs_re} + {1'b0, abs_im};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
      end
      mag <= sum[DW] ? '1 : sum[DW-1:0];
   end
endmodule

// File: rtl/fft_mag_capture.sv
// Captures one FFT output frame as |re|+|im| magnitudes into a dual-port RAM for host readout.
module fft_mag_capture import fft_cap_pkg::*; #(
   parameter int unsigned AW = AW_DEF,
   parameter int unsigned DW = DW_DEF
) (
   input logic      clk,
   input logic      rst,
   fft_cap_if.slave bus
);
   localparam logic [AW-1:0] LAST = '1;

   cap_state_t    state;
   logic [AW-1:0] cnt;
   logic [AW-1:0] wr_addr;
   logic          busy_q;
   logic          done_q;
   logic          err_q;
   logic          acc;
   logic [AW-1:0] acc_addr;
   logic          mag_valid;
   logic [DW-1:0] mag;
   logic [DW-1:0] rd_data_q;
   logic          rd_valid_q;
   logic [DW-1:0] mem [0:(1<<AW)-1];

   // A start-of-frame bin always lands at address 0, both on first capture and on restart.
   always_comb begin
      acc      = bus.opd && ((state == ARMED && bus.sod) || state == CAPTURE);
      acc_addr = bus.sod ? '0 : cnt;
   end

   fft_cap_mag #(.DW(DW)) u_mag (
      .clk      (clk),
      .rst      (rst),
      .in_valid (acc),
      .re       (bus.xk_re),
      .im       (bus.xk_im),
      .out_valid(mag_valid),
      .mag      (mag)
   );

   always_ff @(posedge clk) begin
      wr_addr <= acc_addr;
   end

   // Write enable is masked by rst so a pending magnitude is dropped on reset.
   always_ff @(posedge clk) begin
      if (mag_valid && !rst) begin
         mem[wr_addr] <= mag;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         rd_valid_q <= bus.rd_en;
         if (bus.rd_en) begin
            rd_data_q <= mem[bus.rd_addr];
         end
      end
   end

   // State moves to DONE with the last bin; done/busy follow one edge later, with the final RAM write.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.arm) begin
                  state  <= ARMED;
                  busy_q <= 1'b1;
                  done_q <= 1'b0;
                  err_q  <= 1'b0;
               end else if (state == DONE) begin
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
               end
            end
            ARMED: begin
               if (bus.opd && bus.sod) begin
                  state <= CAPTURE;
                  cnt   <= AW'(1);
               end
            end
            CAPTURE: begin
               if (bus.opd) begin
                  if (bus.sod) begin
                     err_q <= 1'b1;
                     cnt   <= AW'(1);
                  end else if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= DONE;
                  end else begin
                     cnt <= cnt + AW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.err      = err_q;
   assign bus.rd_data  = rd_data_q;
   assign bus.rd_valid = rd_valid_q;
endmodule
